// File: rtl/keyb_pkg.sv
// Shared types and decode helpers for the keypad token front end.
// Covers the token class and op codes, the 4x4 key map and one-hot helpers.
package keyb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HELD,
    ST_REPEAT,
    ST_LOCK
  } key_state_t;

  localparam logic [2:0] CLS_NUM = 3'd0;
  localparam logic [2:0] CLS_OP  = 3'd1;
  localparam logic [2:0] CLS_EQ  = 3'd2;
  localparam logic [2:0] CLS_CLR = 3'd3;
  localparam logic [2:0] CLS_RAW = 3'd4;

  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_DIV = 4'd4;

  typedef struct packed {
    logic [2:0] cls;
    logic [3:0] val;
  } key_tok_t;

  function automatic key_tok_t map_4x4(input logic [3:0] k);
    key_tok_t t;
    t.cls = CLS_NUM;
    t.val = 4'd0;
    case (k)
      4'd0:  t.val = 4'd1;
      4'd1:  t.val = 4'd2;
      4'd2:  t.val = 4'd3;
      4'd3:  begin t.cls = CLS_OP; t.val = OP_ADD; end
      4'd4:  t.val = 4'd4;
      4'd5:  t.val = 4'd5;
      4'd6:  t.val = 4'd6;
      4'd7:  begin t.cls = CLS_OP; t.val = OP_SUB; end
      4'd8:  t.val = 4'd7;
      4'd9:  t.val = 4'd8;
      4'd10: t.val = 4'd9;
      4'd11: begin t.cls = CLS_OP; t.val = OP_MUL; end
      4'd12: t.cls = CLS_CLR;
      4'd14: begin t.cls = CLS_OP; t.val = OP_DIV; end
      4'd15: t.cls = CLS_EQ;
      default: t.val = 4'd0;  // k13 is digit 0
    endcase
    return t;
  endfunction

  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

  function automatic logic [4:0] onehot_idx(input logic [31:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keyb_decoder_fifo_fifo.sv
// Show-ahead token queue: the head entry is held in a register so it is
// visible the cycle after the push, and keeps its last value when empty.
module keyb_tok_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 7,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          ready,
  input  logic          ovf_clr,
  output logic          valid,
  output logic [DW-1:0] dout,
  output logic [LW-1:0] level,
  output logic          overflow
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_next;
  logic [LW-1:0] remain;
  logic          full, pop, push_ok, drop;

  assign valid   = (level != '0);
  assign full    = (level == LW'(DEPTH));
  assign pop     = valid && ready;
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;
  assign rd_next = rd_ptr + AW'(pop);
  assign remain  = level - LW'(pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      dout     <= '0;
      overflow <= 1'b0;
    end else begin
      rd_ptr <= rd_next;
      wr_ptr <= wr_ptr + AW'(push_ok);
      level  <= remain + LW'(push_ok);
      // Head comes from storage if anything survives the pop, else from the bypass.
      if (remain != '0) dout <= mem[rd_next];
      else if (push_ok) dout <= din;
      if (drop) overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/keyb_decoder_fifo.sv
// Keypad decoder: turns scanner codes into typed tokens with rollover,
// digit auto-repeat and malformed-code lockout, queued for the calculator.
module keyb_decoder_fifo
  import keyb_pkg::*;
#(
  parameter int ROWS          = 4,
  parameter int COLS          = 4,
  parameter int FIFO_DEPTH    = 4,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_DELAY  = 500000,
  parameter int REPEAT_PERIOD = 100000,
  localparam int VW = ($clog2(ROWS * COLS) > 4) ? $clog2(ROWS * COLS) : 4,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 btn_press_in,
  input  logic [COLS+ROWS-1:0] btn_id,
  output logic                 tok_valid,
  input  logic                 tok_ready,
  output logic [2:0]           tok_class,
  output logic [VW-1:0]        tok_val,
  output logic [LW-1:0]        fifo_level,
  output logic                 err_invalid,
  output logic                 overflow,
  input  logic                 ovf_clr
);

  logic [ROWS-1:0] row_f;
  logic [COLS-1:0] col_f;
  logic [4:0]      row_pos, col_pos;
  logic [VW-1:0]   key_idx;
  logic            code_ok;
  logic [2:0]      in_cls;
  logic [VW-1:0]   in_val;

  assign row_f   = btn_id[ROWS-1:0];
  assign col_f   = btn_id[ROWS+COLS-1:ROWS];
  assign code_ok = is_onehot(32'(row_f)) && is_onehot(32'(col_f));
  assign row_pos = onehot_idx(32'(row_f));
  assign col_pos = onehot_idx(32'(col_f));
  // Rows and columns are numbered from the field MSB.
  assign key_idx = VW'((32'(ROWS - 1) - 32'(row_pos)) * 32'(COLS)
                     + (32'(COLS - 1) - 32'(col_pos)));

  generate
    if (ROWS == 4 && COLS == 4) begin : g_map
      key_tok_t map_tok;
      assign map_tok = map_4x4(key_idx[3:0]);
      assign in_cls  = map_tok.cls;
      assign in_val  = VW'(map_tok.val);
    end else begin : g_raw
      assign in_cls = CLS_RAW;
      assign in_val = key_idx;
    end
  endgenerate

  key_state_t           state;
  logic [31:0]          cnt;
  logic [COLS+ROWS-1:0] cur_id;
  logic [2:0]           cur_cls;
  logic [VW-1:0]        cur_val;
  logic                 active, changed, is_new, is_bad, is_rep, push;

  assign active  = (state == ST_HELD) || (state == ST_REPEAT);
  assign changed = (btn_id != cur_id);
  assign is_new  = btn_press_in && code_ok && ((state == ST_IDLE) || (active && changed));
  assign is_bad  = btn_press_in && !code_ok && ((state == ST_IDLE) || (active && changed));
  assign is_rep  = btn_press_in && active && !changed && (cnt == 32'd0)
                   && ((state == ST_REPEAT) || (REPEAT_EN != 0 && cur_cls == CLS_NUM));
  assign push    = is_new || is_rep;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      cur_id      <= '0;
      cur_cls     <= CLS_NUM;
      cur_val     <= '0;
      err_invalid <= 1'b0;
    end else begin
      err_invalid <= is_bad;
      if (is_new) begin
        state   <= ST_HELD;
        cnt     <= 32'(REPEAT_DELAY - 1);
        cur_id  <= btn_id;
        cur_cls <= in_cls;
        cur_val <= in_val;
      end else if (is_bad) begin
        state <= ST_LOCK;
      end else if (is_rep) begin
        state <= ST_REPEAT;
        cnt   <= 32'(REPEAT_PERIOD - 1);
      end else begin
        case (state)
          ST_HELD, ST_REPEAT: begin
            if (!btn_press_in) state <= ST_IDLE;
            else if (cnt != 32'd0) cnt <= cnt - 32'd1;
          end
          ST_LOCK: if (!btn_press_in) state <= ST_IDLE;
          default: ;
        endcase
      end
    end
  end

  logic [VW+2:0] fifo_din, fifo_dout;

  assign fifo_din  = is_new ? {in_cls, in_val} : {cur_cls, cur_val};
  assign tok_class = fifo_dout[VW+2:VW];
  assign tok_val   = fifo_dout[VW-1:0];

  keyb_tok_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (VW + 3)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .din      (fifo_din),
    .ready    (tok_ready),
    .ovf_clr  (ovf_clr),
    .valid    (tok_valid),
    .dout     (fifo_dout),
    .level    (fifo_level),
    .overflow (overflow)
  );

endmodule

// File: doc/keyb_decoder_fifo.md
Name: keyb_decoder_fifo

Overview:
Parametrised keypad decoder for the calculator front end. Takes the scanner's {column, row} one-hot code and a key-held level. Turns each key press into a typed token: number, operator, equals, clear or raw index. Tokens queue in a small FIFO and are drained by the calculator FSM over a valid/ready handshake. Adds checking of malformed codes, rollover to a new key while held, optional auto-repeat of digits, and overflow reporting.

Parameters:
ROWS, 4, keypad rows; row one-hot field width
COLS, 4, keypad columns; column one-hot field width
FIFO_DEPTH, 4, token queue entries; power of two, at least 2
REPEAT_EN, 1, 1 enables auto-repeat of digit keys
REPEAT_DELAY, 500000, held cycles before the first repeat; at least 2
REPEAT_PERIOD, 100000, cycles between later repeats; at least 2
VW (derived), max(4, clog2(ROWS*COLS)), token value width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
btn_press_in  in  1  level; a key is currently held (from scanner)
btn_id  in  COLS+ROWS  {col one-hot [MSB field], row one-hot [LSB field]}
tok_valid  out  1  FIFO head holds a token
tok_ready  in  1  consumer accepts the head token this cycle
tok_class  out  3  head token class: NUM=0, OP=1, EQ=2, CLR=3, RAW=4
tok_val  out  VW  digit 0-9, op code (ADD=1, SUB=2, MUL=3, DIV=4) or raw key index; 0 for EQ and CLR
fifo_level  out  clog2(FIFO_DEPTH)+1  stored token count
err_invalid  out  1  one-cycle pulse on a malformed code
overflow  out  1  sticky; a token was dropped because the FIFO was full
ovf_clr  in  1  clears overflow

Behaviour:
- Reset (reset=0, asynchronous): FSM to IDLE, FIFO empty, counters 0.
  - Outputs: tok_valid=0, tok_class=0, tok_val=0, fifo_level=0, err_invalid=0, overflow=0.
- Key index: k = r*COLS + c.
  - r = position of the set row bit counted from the row-field MSB (top row = 0).
  - c = position of the set column bit counted from the column-field MSB.
- Map for k<16, used only when ROWS=COLS=4:
  - k0..2 = digits 1..3; k3 = ADD
  - k4..6 = digits 4..6; k7 = SUB
  - k8..10 = digits 7..9; k11 = MUL
  - k12 = CLR; k13 = digit 0; k14 = DIV; k15 = EQ
  - Any other geometry: every key is class RAW with tok_val = k.
- Valid code: exactly one row bit and exactly one column bit set. Anything else is malformed.
- FSM states: IDLE, HELD, REPEAT, LOCK. All decisions use btn_press_in/btn_id sampled at the current edge.
  - IDLE, press with valid code: push token, load counter with REPEAT_DELAY, go HELD.
  - IDLE, press with malformed code: pulse err_invalid, no push, go LOCK.
  - HELD or REPEAT, btn_press_in=0: go IDLE, no push.
  - HELD or REPEAT, btn_id changes to a valid code: rollover; push the new token, reload REPEAT_DELAY, go HELD.
  - HELD or REPEAT, btn_id changes to a malformed code: pulse err_invalid, go LOCK.
  - HELD, REPEAT_EN=1, class NUM, counter reaches 0: push the same token, load REPEAT_PERIOD, go REPEAT.
  - REPEAT, counter reaches 0: push the same token, reload REPEAT_PERIOD.
  - Non-digit keys never repeat; HELD simply waits for release.
  - LOCK: waits for btn_press_in=0, then goes IDLE. No pushes in LOCK.
- Latency: a press sampled at edge E is written to the FIFO at E. With the FIFO empty, tok_valid=1 from E until it is popped.
- FIFO (show-ahead):
  - Pop when tok_valid and tok_ready are both 1.
  - Empty: tok_valid=0, and tok_class/tok_val hold their last values.
  - Full with push and no pop: token dropped, overflow set, fifo_level unchanged.
  - Full with push and pop in the same cycle: both happen, no overflow.
  - Empty with push and pop in the same cycle: the pop is ignored, because tok_valid was 0.
- overflow: ovf_clr=1 clears it. If a new drop happens in the same cycle, the set wins.
- Counters are 32-bit down-counters. Pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Package keyb_pkg:
  - token class constants; op code constants
  - key-index-to-token map function for 4x4
  - one-hot validity function; one-hot-to-index function
- Sub-module keyb_tok_fifo: parametrised show-ahead FIFO holding {class, value}, with level, full and overflow logic.
- The top level holds the FSM, repeat counter and decode.

Test Plan:
- Press 8'b01000001 for 3 cycles, then release -> one token {NUM, 0}, tok_valid 1 cycle later, fifo_level=1, no repeat.
- Press 8'b00010001, then 8'b00011000, then 8'b10001000, each separated by a release -> tokens {EQ,0}, {OP,ADD}, {NUM,1} in order.
- Press 8'b11000001 -> err_invalid for exactly 1 cycle, no token; still no token while held; a valid press after release decodes normally.
- REPEAT_DELAY=10, REPEAT_PERIOD=4; hold 8'b01000100 for 25 cycles -> tokens {NUM,5} at cycles 0, 10, 14, 18, 22. Holding 8'b00011000 the same way gives only one {OP,ADD}.
- tok_ready=0 with FIFO_DEPTH=4; make 5 presses -> fifo_level=4, overflow=1. The 5th token is lost; the first 4 drain in order once tok_ready=1. ovf_clr clears overflow.
- Pull reset low while in REPEAT with 2 queued tokens -> outputs go to zero immediately; after reset is released, a held key is treated as a new press from IDLE.
